// File: rtl/gray_ptr_sync_cmp_if.sv
// Signal bundle between an async-FIFO pointer synchroniser/comparator and its user.
// The user side drives the pointers and error clear; the comparator returns sync results and flags.
interface gray_ptr_sync_cmp_if #(
    parameter int ADDR_WIDTH = 4
);
    localparam int W = ADDR_WIDTH + 1;

    logic [W-1:0] i_remote_gray;
    logic [W-1:0] i_local_bin;
    logic         i_err_clr;
    logic [W-1:0] o_sync_gray;
    logic [W-1:0] o_sync_bin;
    logic [W-1:0] o_level;
    logic         o_full;
    logic         o_empty;
    logic         o_gray_err;

    modport master (
        output i_remote_gray, i_local_bin, i_err_clr,
        input  o_sync_gray, o_sync_bin, o_level, o_full, o_empty, o_gray_err
    );

    modport slave (
        input  i_remote_gray, i_local_bin, i_err_clr,
        output o_sync_gray, o_sync_bin, o_level, o_full, o_empty, o_gray_err
    );
endinterface

// File: rtl/gray_ptr_sync_cmp.sv
// Synchronises a remote Gray pointer into clk, converts it to binary and derives level/full/empty.
// Also watches the synchronised pointer for multi-bit steps and latches a sticky error.
module gray_ptr_sync_cmp #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    gray_ptr_sync_cmp_if.slave    bus
);
    localparam int           W    = ADDR_WIDTH + 1;
    localparam logic [W-1:0] HALF = W'(1) << ADDR_WIDTH;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("gray_ptr_sync_cmp: SYNC_STAGES must be in 2..4");
        end
        if (MODE != 0 && MODE != 1) begin : g_bad_mode
            $error("gray_ptr_sync_cmp: MODE must be 0 or 1");
        end
    endgenerate

    (* async_reg = "true", keep = "true" *) logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] sync_d [SYNC_STAGES];

    logic [W-1:0] sync_gray;
    logic [W-1:0] sync_bin_q, sync_bin_d;
    logic [W-1:0] level_q, level_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;
    logic [W-1:0] hist_q, hist_d;
    logic         hist_vld_q, hist_vld_d;
    logic         gray_err_q, gray_err_d;
    logic [W-1:0] gray_diff;
    logic         gray_viol;

    // Pure shift chain: nothing may sit between stages.
    always_comb begin
        sync_d[0] = bus.i_remote_gray;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync_gray = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_bin_d = '0;
        for (int i = 0; i < W; i++) begin
            sync_bin_d[i] = ^(sync_gray >> i);
        end
    end

    always_comb begin
        level_d = '0;
        if (MODE == 0) begin
            level_d = bus.i_local_bin - sync_bin_q;
        end else begin
            level_d = sync_bin_q - bus.i_local_bin;
        end
        full_d  = (MODE == 0) && (level_d == HALF);
        empty_d = (MODE == 1) && (level_d == '0);
    end

    // A legal Gray step changes at most one bit; clearing x & (x-1) leaves bits only if two or more were set.
    always_comb begin
        hist_d     = sync_gray;
        hist_vld_d = 1'b1;
        gray_diff  = sync_gray ^ hist_q;
        gray_viol  = hist_vld_q && ((gray_diff & (gray_diff - W'(1))) != '0);
        gray_err_d = gray_viol | (gray_err_q & ~bus.i_err_clr);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            sync_bin_q <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= (MODE == 1);
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
            gray_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            sync_bin_q <= sync_bin_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            hist_q     <= hist_d;
            hist_vld_q <= hist_vld_d;
            gray_err_q <= gray_err_d;
        end
    end

    assign bus.o_sync_gray = sync_gray;
    assign bus.o_sync_bin  = sync_bin_q;
    assign bus.o_level     = level_q;
    assign bus.o_full      = full_q;
    assign bus.o_empty     = empty_q;
    assign bus.o_gray_err  = gray_err_q;
endmodule
